// File: rtl/m_risc.sv
// m_risc: 16-bit multi-cycle RISC core with one shared instruction/data memory port.
// Sequencing is FETCH -> EXEC (-> MEM for LOAD/STORE) -> FETCH. HALT is absorbing until reset.
module m_risc (
    input  logic        CLK,
    input  logic        reset,
    output logic        escmem,
    output logic [15:0] endereco,
    output logic [15:0] valorescrito,
    input  logic [15:0] valorlido
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        MEM   = 2'd2,
        HALT  = 2'd3
    } state_t;

    localparam logic [3:0] OP_ALU   = 4'h1;
    localparam logic [3:0] OP_HALT  = 4'h2;
    localparam logic [3:0] OP_LDI   = 4'h3;
    localparam logic [3:0] OP_LUI   = 4'h4;
    localparam logic [3:0] OP_LOAD  = 4'h5;
    localparam logic [3:0] OP_STORE = 4'h6;
    localparam logic [3:0] OP_JR    = 4'h7;
    localparam logic [3:0] OP_BR    = 4'h8;

    // Architectural state
    state_t      state_reg, state_next;
    logic [15:0] reg_pc, pc_next;
    logic [15:0] ri, ri_next;
    logic [15:0] banco [0:7];
    logic [7:0]  banco_flags, flags_next;

    // Register-file write request produced by the control logic
    logic        reg_we;
    logic [2:0]  reg_waddr;
    logic [15:0] reg_wdata;

    // Instruction fields, always decoded from the latched instruction
    logic [3:0]  op;
    logic [2:0]  rd, ra, rb, fn;
    logic [15:0] rd_val, ra_val, rb_val;

    assign op     = ri[15:12];
    assign rd     = ri[11:9];
    assign ra     = ri[8:6];
    assign rb     = ri[5:3];
    assign fn     = ri[2:0];
    assign rd_val = banco[rd];
    assign ra_val = banco[ra];
    assign rb_val = banco[rb];

    // ALU datapath
    logic [15:0] b_op;
    logic [16:0] sum;
    logic [15:0] alu_res;
    logic        alu_c, alu_v, alu_z;

    // ALU: SUB reuses the adder as ra + ~rb + 1, so Carry means "no borrow"
    always_comb begin
        b_op    = (fn == 3'b001) ? ~rb_val : rb_val;
        sum     = {1'b0, ra_val} + {1'b0, b_op} + {16'd0, (fn == 3'b001)};
        alu_res = 16'd0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (fn)
            3'b000, 3'b001: begin
                alu_res = sum[15:0];
                alu_c   = sum[16];
                alu_v   = (ra_val[15] == b_op[15]) && (sum[15] != ra_val[15]);
            end
            3'b010: alu_res = ra_val & rb_val;
            3'b011: alu_res = ra_val | rb_val;
            3'b100: alu_res = ra_val ^ rb_val;
            3'b101: alu_res = ~ra_val;
            3'b110: begin
                alu_res = {ra_val[14:0], 1'b0};
                alu_c   = ra_val[15];
            end
            3'b111: begin
                alu_res = {1'b0, ra_val[15:1]};
                alu_c   = ra_val[0];
            end
        endcase
        alu_z = (alu_res == 16'd0);
    end

    // Next-state, PC, instruction, flag and register-write control
    always_comb begin
        state_next = state_reg;
        pc_next    = reg_pc;
        ri_next    = ri;
        flags_next = banco_flags;
        reg_we     = 1'b0;
        reg_waddr  = rd;
        reg_wdata  = 16'd0;
        case (state_reg)
            FETCH: begin
                ri_next    = valorlido;
                pc_next    = reg_pc + 16'd1;
                state_next = EXEC;
            end
            EXEC: begin
                state_next = FETCH;
                case (op)
                    OP_ALU: begin
                        reg_we     = 1'b1;
                        reg_wdata  = alu_res;
                        // {NegZero, Carry, Zero, Neg, Overflow, rsvd, rsvd, True}
                        flags_next = {alu_res[15] | alu_z, alu_c, alu_z, alu_res[15],
                                      alu_v, 2'b00, 1'b1};
                    end
                    OP_HALT: state_next = HALT;
                    OP_LDI: begin
                        reg_we    = 1'b1;
                        reg_wdata = {{7{ri[8]}}, ri[8:0]};
                    end
                    OP_LUI: begin
                        reg_we    = 1'b1;
                        reg_wdata = {ri[7:0], rd_val[7:0]};
                    end
                    OP_LOAD, OP_STORE: state_next = MEM;
                    OP_JR: pc_next = ra_val;
                    OP_BR: begin
                        // PC already points past the branch, so offset is relative to BR+1
                        if (banco_flags[rd] == ri[8])
                            pc_next = reg_pc + {{8{ri[7]}}, ri[7:0]};
                    end
                    default: ;
                endcase
            end
            MEM: begin
                state_next = FETCH;
                if (op == OP_LOAD) begin
                    reg_we    = 1'b1;
                    reg_wdata = valorlido;
                end
            end
            HALT: ;
        endcase
    end

    // Memory port: data address and store strobe only in MEM, otherwise the PC drives the bus
    always_comb begin
        endereco     = reg_pc;
        escmem       = 1'b0;
        valorescrito = 16'd0;
        if (state_reg == MEM) begin
            endereco = ra_val;
            if (op == OP_STORE) begin
                escmem       = 1'b1;
                valorescrito = rb_val;
            end
        end
    end

    // Control registers; async reset so escmem falls immediately when reset rises
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_reg   <= FETCH;
            reg_pc      <= 16'd0;
            ri          <= 16'd0;
            banco_flags <= 8'h01;
        end else begin
            state_reg   <= state_next;
            reg_pc      <= pc_next;
            ri          <= ri_next;
            banco_flags <= flags_next;
        end
    end

    // Register file: one write port, operands read combinationally so rd = ra sees the old value
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 8; i++)
                banco[i] <= 16'd0;
        end else if (reg_we) begin
            banco[reg_waddr] <= reg_wdata;
        end
    end

endmodule

// File: tb/tb_m_risc.sv
// tb_m_risc: table of short programs run to HALT, registers/flags/PC checked at halt,
// stores checked through a scoreboard as the core writes memory; plus a reset-during-STORE sequence.
module tb_m_risc;

    logic        CLK;
    logic        reset;
    logic        escmem;
    logic [15:0] endereco;
    logic [15:0] valorescrito;
    logic [15:0] valorlido;

    m_risc dut (
        .CLK          (CLK),
        .reset        (reset),
        .escmem       (escmem),
        .endereco     (endereco),
        .valorescrito (valorescrito),
        .valorlido    (valorlido)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Memory model: combinational read, write on the rising edge; tb loads through its own port
    logic [15:0] mem [0:65535];
    logic        clr_all, ld_en;
    logic [15:0] ld_addr, ld_data;

    assign valorlido = mem[endereco];

    always @(posedge CLK) begin
        if (clr_all) begin
            for (int i = 0; i < 65536; i++)
                mem[i] <= 16'd0;
        end else if (ld_en) begin
            mem[ld_addr] <= ld_data;
        end else if (escmem) begin
            mem[endereco] <= valorescrito;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Store scoreboard
    typedef struct packed {
        logic [15:0] addr;
        logic [15:0] data;
    } st_t;
    st_t sb[$];

    always @(negedge CLK) begin
        if (escmem) begin
            if (sb.size() == 0) begin
                check("unexpected_store", {endereco, valorescrito}, 32'h0);
            end else begin
                st_t e;
                e = sb.pop_front();
                check("store_addr", {16'h0, endereco}, {16'h0, e.addr});
                check("store_data", {16'h0, valorescrito}, {16'h0, e.data});
                $display("store: mem[%h] <= %h", endereco, valorescrito);
            end
        end
    end

    // Program words for all vectors, back to back
    logic [15:0] rom [0:46] = '{
        16'h3207, 16'h3403, 16'h1650, 16'h2FFF,                       // 0: LDI/LDI/ADD/HALT
        16'h33FF, 16'h1248, 16'h2FFF,                                 // 1: -1 + -1
        16'h3210, 16'h3455, 16'h6050, 16'h5640, 16'h2FFF,             // 2: store/load
        16'h3203, 16'h3403, 16'h1651, 16'h8B01, 16'h3801, 16'h8C01,
        16'h3A02, 16'h2FFF,                                           // 3: SUB zero + BRs
        16'h3205, 16'h1409, 16'h2FFF,                                 // 4: 0 - 5
        16'h32F0, 16'h42AB, 16'h1447, 16'h1654, 16'h1846, 16'h3A0A,
        16'h7140, 16'h3C01, 16'h3C01, 16'h3C01, 16'h1C05, 16'h2FFF,   // 5: LUI/shift/XOR/JR/NOT
        16'h32FF, 16'h427F, 16'h1448, 16'h6050, 16'h1652, 16'h2FFF,   // 6: overflow, AND
        16'h3204, 16'h3407, 16'h443A, 16'h6050, 16'h0000, 16'h2FFF    // 7: store to next PC
    };

    typedef struct packed {
        int           base;
        int           len;
        int           cyc;
        logic [15:0]  hpc;
        logic [7:0]   fl;
        logic [127:0] regs;
        int           nst;
        logic [15:0]  sa;
        logic [15:0]  sd;
    } vec_t;
    vec_t vecs [8];

    task automatic setv(input int k, input int base, input int len, input int cyc,
                        input logic [15:0] hpc, input logic [7:0] fl,
                        input logic [15:0] r1, input logic [15:0] r2, input logic [15:0] r3,
                        input logic [15:0] r4, input logic [15:0] r5, input logic [15:0] r6,
                        input int nst, input logic [15:0] sa, input logic [15:0] sd);
        vecs[k].base = base;
        vecs[k].len  = len;
        vecs[k].cyc  = cyc;
        vecs[k].hpc  = hpc;
        vecs[k].fl   = fl;
        vecs[k].regs = {16'h0, r6, r5, r4, r3, r2, r1, 16'h0};
        vecs[k].nst  = nst;
        vecs[k].sa   = sa;
        vecs[k].sd   = sd;
    endtask

    // Reset the core, clear memory and load a program while reset is held
    task automatic reset_and_load(input int base, input int len);
        reset = 1'b1;
        #1;
        check("rst_escmem", {31'h0, escmem}, 32'h0);
        check("rst_endereco", {16'h0, endereco}, 32'h0);
        check("rst_valorescrito", {16'h0, valorescrito}, 32'h0);
        check("rst_flags", {24'h0, dut.banco_flags}, 32'h01);
        clr_all = 1'b1;
        @(posedge CLK);
        #1;
        clr_all = 1'b0;
        for (int w = 0; w < len; w++) begin
            ld_en   = 1'b1;
            ld_addr = w[15:0];
            ld_data = rom[base + w];
            @(posedge CLK);
            #1;
        end
        ld_en = 1'b0;
    endtask

    task automatic check_regs(input logic [127:0] regs);
        for (int r = 0; r < 8; r++)
            check($sformatf("R%0d", r), {16'h0, dut.banco[r]}, {16'h0, regs[r*16 +: 16]});
    endtask

    task automatic run_vec(input int k);
        vec_t v;
        v = vecs[k];
        reset_and_load(v.base, v.len);
        sb.delete();
        if (v.nst > 0)
            sb.push_back('{addr: v.sa, data: v.sd});
        @(negedge CLK);
        reset = 1'b0;
        #1;
        check("start_addr", {16'h0, endereco}, 32'h0);
        repeat (v.cyc) @(posedge CLK);
        #1;
        check("halt_pc", {16'h0, endereco}, {16'h0, v.hpc});
        check("flags", {24'h0, dut.banco_flags}, {24'h0, v.fl});
        check_regs(v.regs);
        repeat (3) @(posedge CLK);
        #1;
        check("halt_stays", {16'h0, endereco}, {16'h0, v.hpc});
        check("halt_escmem", {31'h0, escmem}, 32'h0);
        check("stores_done", sb.size(), 32'h0);
        $display("vec %0d: pc=%h flags=%h", k, endereco, dut.banco_flags);
    endtask

    initial begin
        reset   = 1'b1;
        clr_all = 1'b0;
        ld_en   = 1'b0;
        ld_addr = 16'h0;
        ld_data = 16'h0;

        setv(0, 0,  4,  8, 16'h0004, 8'h01, 16'h0007, 16'h0003, 16'h000A, 16'h0, 16'h0, 16'h0, 0, 16'h0, 16'h0);
        setv(1, 4,  3,  6, 16'h0003, 8'hD1, 16'hFFFE, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 0, 16'h0, 16'h0);
        setv(2, 7,  5, 12, 16'h0005, 8'h01, 16'h0010, 16'h0055, 16'h0055, 16'h0, 16'h0, 16'h0, 1, 16'h0010, 16'h0055);
        setv(3, 12, 8, 16, 16'h0008, 8'hE1, 16'h0003, 16'h0003, 16'h0000, 16'h0000, 16'h0002, 16'h0, 0, 16'h0, 16'h0);
        setv(4, 20, 3,  6, 16'h0003, 8'h91, 16'h0005, 16'hFFFB, 16'h0, 16'h0, 16'h0, 16'h0, 0, 16'h0, 16'h0);
        setv(5, 23, 12, 18, 16'h000C, 8'h91, 16'hABF0, 16'h55F8, 16'hFE08, 16'h57E0, 16'h000A, 16'hFFFF, 0, 16'h0, 16'h0);
        setv(6, 35, 6, 13, 16'h0006, 8'h01, 16'h7FFF, 16'hFFFE, 16'h7FFE, 16'h0, 16'h0, 16'h0, 1, 16'h7FFF, 16'hFFFE);
        setv(7, 41, 6, 13, 16'h0006, 8'h01, 16'h0004, 16'h3A07, 16'h0, 16'h0, 16'h0007, 16'h0, 1, 16'h0004, 16'h3A07);

        for (int k = 0; k < 8; k++)
            run_vec(k);

        // Reset asserted in the MEM cycle of a STORE: strobe must drop at once and no write happens
        reset_and_load(7, 5);
        sb.delete();
        @(negedge CLK);
        reset = 1'b0;
        repeat (6) @(posedge CLK);
        #1;
        check("mem_escmem", {31'h0, escmem}, 32'h1);
        check("mem_endereco", {16'h0, endereco}, 32'h0010);
        check("mem_valorescrito", {16'h0, valorescrito}, 32'h0055);
        #1;
        reset = 1'b1;
        #1;
        check("arst_escmem", {31'h0, escmem}, 32'h0);
        check("arst_endereco", {16'h0, endereco}, 32'h0);
        check("arst_valorescrito", {16'h0, valorescrito}, 32'h0);
        check("arst_pc", {16'h0, dut.reg_pc}, 32'h0);
        check("arst_flags", {24'h0, dut.banco_flags}, 32'h01);
        check("arst_R1", {16'h0, dut.banco[1]}, 32'h0);
        @(posedge CLK);
        #1;
        check("arst_no_write", {16'h0, mem[16'h0010]}, 32'h0);
        $display("reset during store: escmem=%b mem[0010]=%h", escmem, mem[16'h0010]);

        // Restart from address 0 with the program still in memory
        sb.push_back('{addr: 16'h0010, data: 16'h0055});
        @(negedge CLK);
        reset = 1'b0;
        #1;
        check("restart_addr", {16'h0, endereco}, 32'h0);
        repeat (12) @(posedge CLK);
        #1;
        check("restart_pc", {16'h0, endereco}, 32'h0005);
        check("restart_R3", {16'h0, dut.banco[3]}, 32'h0055);
        check("restart_stores", sb.size(), 32'h0);
        $display("restart: pc=%h R3=%h", endereco, dut.banco[3]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
